light_source_arbiter: RTL and testbench
=======================================

# light_source_arbiter

Parametrised, registered successor to the single-cycle light-state multiplexer. It selects one of `N_SRC` controller sources (fixed-time plans, reset plan, online override, …) by fixed priority and drives the light state. When ownership changes away from a non-RED output, it forces a safe YELLOW→RED handover before adopting the new source. It sits between the per-mode controllers and the lamp driver.

## Interface
Parameters:
- `N_SRC`, 6: number of sources, ≥2.
- `YEL_CYC`, 3: handover YELLOW duration in cycles, ≥1.
- `RED_CYC`, 2: handover all-RED duration in cycles, ≥1.
- `FALLBACK`, 2'b00 (RED): output when no source requests.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `N_SRC`: per-source request; bit 0 has the highest priority.
- `src_state` in `2*N_SRC`: packed source states; source i at `[2i+1:2i]`.
- `state` out 2: registered light state (00 RED, 01 YELLOW, 10 GREEN).
- `owner` out `$clog2(N_SRC+1)`: current owning source index; value `N_SRC` = none.
- `switching` out 1: high while in handover.
- `conflict` out 1: registered; high when more than one `req` bit was set in the previous cycle.
- `undef_in` out 1: registered; high when the owner's source state was 2'b11 in the previous cycle.

## Operation
- `winner` (combinational): lowest set index of `req`, or `N_SRC` if `req`==0.
- FSM states: PASS, HANDOVER_YEL, HANDOVER_RED.
- PASS, `winner`==`owner`:
  - `state` <= source `owner`'s state, or `FALLBACK` if `owner`==`N_SRC`.
  - A source value of 2'b11 is driven as RED and sets `undef_in`.
- PASS, `winner`≠`owner`:
  - If `state`==RED: `owner` <= `winner` and `state` <= the new owner's mapped value in the same edge; no handover.
  - Otherwise: enter HANDOVER_YEL, `state` <= YELLOW, `cnt` <= `YEL_CYC`-1, `switching` <= 1.
  - A current YELLOW restarts the full `YEL_CYC` count.
- HANDOVER_YEL:
  - `state` holds YELLOW; `cnt` decrements each cycle.
  - At `cnt`==0: go to HANDOVER_RED, `state` <= RED, `cnt` <= `RED_CYC`-1.
- HANDOVER_RED:
  - `state` holds RED; `cnt` decrements each cycle.
  - At `cnt`==0: `owner` <= `winner` sampled on that cycle, `state` <= that owner's mapped value (or `FALLBACK`), go to PASS, `switching` <= 0.
- A started handover always completes. `req` changes during handover affect only the final target. A final target equal to the old owner is allowed.
- `cnt` width: `$clog2(max(YEL_CYC,RED_CYC)+1)`; it never wraps.

## Timing
- Reset values: `state`=RED, `owner`=`N_SRC`, `switching`=0, `conflict`=0, `undef_in`=0, FSM=PASS, `cnt`=0.
- Reset is immediate and asynchronous, including mid-handover. The first post-reset edge evaluates from PASS with `state` RED, so adoption is immediate.
- Pass-through latency: one cycle from `src_state`/`req` to `state`.
- Handover from a non-RED output:
  - `state` shows YELLOW for exactly `YEL_CYC` cycles, then RED for exactly `RED_CYC` cycles.
  - The new source's value appears on the following edge.
  - `switching` is high for `YEL_CYC`+`RED_CYC` cycles.
- Simultaneous requests resolve by priority in the same cycle; `conflict` rises on the following edge.
- All-zero `req` is itself an ownership change to none, handled by the same rules.

## Structure
- Shared package `tl_pkg`:
  - `light_t` enum with `RED`, `YELLOW`, `GREEN`, `UNDEFINED`.
  - `arb_state_t` enum with `PASS`, `HANDOVER_YEL`, `HANDOVER_RED`.
- One sub-module `prio_enc #(N)`: `req` → `winner` index plus a `multi` flag (≥2 bits set).
- The FSM, counter and output registers live in the top module.

## Test plan
- Reset: assert `rst_n`=0 mid-handover → `state`=RED, `owner`=6, `switching`=0 immediately; release → a source-2 GREEN request appears at `owner`=2, `state`=GREEN one edge later.
- Pass-through: `req`=6'b000100 with source 2 toggling GREEN/YELLOW → `state` follows with 1-cycle latency.
- Safe handover: owner 2 GREEN, then `req`=6'b000001 with source 0 GREEN → YELLOW×3, RED×2, then GREEN, `owner`=0, `switching` high for 5 cycles.
- Immediate adopt: owner 3 outputting RED, then `req` switches to bit 5 → `owner`=5 on the next edge, no YELLOW.
- Conflict and undefined: `req`=6'b000101 → `owner`=0, `conflict`=1; source 0 state=2'b11 → `state`=RED, `undef_in`=1.
- Drop during handover: `req` goes to 0 during HANDOVER_YEL → handover completes, then `owner`=6, `state`=RED (`FALLBACK`).

Source files
------------

// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared types and helpers for the traffic-light source arbiter.
//   light_t     : 2-bit lamp state encoding (RED/YELLOW/GREEN/UNDEFINED)
//   arb_state_t : arbiter FSM states
//   to_light    : maps a raw source code to a drivable lamp state
//   max_int     : elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [1:0] {
    RED       = 2'b00,
    YELLOW    = 2'b01,
    GREEN     = 2'b10,
    UNDEFINED = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    PASS         = 2'b00,
    HANDOVER_YEL = 2'b01,
    HANDOVER_RED = 2'b10
  } arb_state_t;

  // An undefined source code must never reach the lamps; show RED instead.
  function automatic light_t to_light(input logic [1:0] v);
    return (v == 2'b11) ? RED : light_t'(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// ---------------------------------------------------------------------------
// prio_enc
// Fixed-priority encoder: bit 0 has the highest priority.
// Ports:
//   req    in  N              : request vector
//   winner out $clog2(N+1)    : lowest set index, or N when req is all zero
//   multi  out 1              : two or more request bits set
// ---------------------------------------------------------------------------
module prio_enc
  import tl_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]           req,
  output logic [$clog2(N+1)-1:0] winner,
  output logic                   multi
);

  localparam int W = $clog2(N + 1);

  always_comb begin
    winner = W'(N);
    // Scan from the top down so the lowest set index is the last to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = W'(i);
      end
    end
    multi = ($countones(req) > 1);
  end

endmodule

// File: rtl/light_source_arbiter.sv
// ---------------------------------------------------------------------------
// light_source_arbiter
// Selects one of N_SRC light-state sources by fixed priority and drives the
// registered lamp state. Moving ownership away from a non-RED output forces a
// YELLOW (YEL_CYC cycles) then all-RED (RED_CYC cycles) handover before the
// new source is adopted.
// Ports:
//   clk        in  1              : clock, rising edge
//   rst_n      in  1              : asynchronous active-low reset
//   req        in  N_SRC          : per-source request, bit 0 highest priority
//   src_state  in  2*N_SRC        : packed source states, source i at [2i+1:2i]
//   state      out 2              : registered lamp state
//   owner      out clog2(N_SRC+1) : owning source, N_SRC = none
//   switching  out 1              : handover in progress
//   conflict   out 1              : >1 request bit set in previous cycle
//   undef_in   out 1              : driven source was 2'b11 in previous cycle
// ---------------------------------------------------------------------------
module light_source_arbiter
  import tl_pkg::*;
#(
  parameter int          N_SRC    = 6,
  parameter int          YEL_CYC  = 3,
  parameter int          RED_CYC  = 2,
  parameter logic [1:0]  FALLBACK = 2'b00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_SRC-1:0]             req,
  input  logic [2*N_SRC-1:0]           src_state,
  output logic [1:0]                   state,
  output logic [$clog2(N_SRC+1)-1:0]   owner,
  output logic                         switching,
  output logic                         conflict,
  output logic                         undef_in
);

  localparam int            OW       = $clog2(N_SRC + 1);
  localparam int            CW       = $clog2(max_int(YEL_CYC, RED_CYC) + 1);
  localparam logic [OW-1:0] NONE     = OW'(N_SRC);
  localparam logic [CW-1:0] YEL_LOAD = CW'(YEL_CYC - 1);
  localparam logic [CW-1:0] RED_LOAD = CW'(RED_CYC - 1);

  arb_state_t    r_fsm;
  light_t        r_state;
  logic [OW-1:0] r_owner;
  logic [CW-1:0] r_cnt;
  logic          r_switching;
  logic          r_conflict;
  logic          r_undef;

  logic [OW-1:0] w_winner;
  logic          w_multi;
  logic [1:0]    w_src [N_SRC];
  logic [1:0]    w_own_raw;
  logic [1:0]    w_win_raw;
  light_t        w_own_light;
  light_t        w_win_light;
  logic          w_own_undef;
  logic          w_win_undef;

  prio_enc #(.N(N_SRC)) u_prio_enc (
    .req    (req),
    .winner (w_winner),
    .multi  (w_multi)
  );

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign w_src[gi] = src_state[2*gi +: 2];
  end

  // Raw codes of the current owner and of the priority winner.
  always_comb begin
    w_own_raw = 2'b00;
    w_win_raw = 2'b00;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_owner == OW'(i)) begin
        w_own_raw = w_src[i];
      end
      if (w_winner == OW'(i)) begin
        w_win_raw = w_src[i];
      end
    end
  end

  // "None" drives FALLBACK and can never be flagged as undefined.
  assign w_own_light = (r_owner == NONE)  ? light_t'(FALLBACK) : to_light(w_own_raw);
  assign w_win_light = (w_winner == NONE) ? light_t'(FALLBACK) : to_light(w_win_raw);
  assign w_own_undef = (r_owner != NONE)  && (w_own_raw == 2'b11);
  assign w_win_undef = (w_winner != NONE) && (w_win_raw == 2'b11);

  // undef_in reflects the source actually feeding the lamps on each edge:
  // the newly adopted source on an adoption edge, otherwise the held owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= PASS;
      r_state     <= RED;
      r_owner     <= NONE;
      r_cnt       <= '0;
      r_switching <= 1'b0;
      r_conflict  <= 1'b0;
      r_undef     <= 1'b0;
    end else begin
      r_conflict <= w_multi;
      case (r_fsm)
        PASS: begin
          if (w_winner == r_owner) begin
            r_state <= w_own_light;
            r_undef <= w_own_undef;
          end else if (r_state == RED) begin
            // Already safe: adopt the new owner without a handover.
            r_owner <= w_winner;
            r_state <= w_win_light;
            r_undef <= w_win_undef;
          end else begin
            // A current YELLOW also restarts the full yellow interval.
            r_fsm       <= HANDOVER_YEL;
            r_state     <= YELLOW;
            r_cnt       <= YEL_LOAD;
            r_switching <= 1'b1;
            r_undef     <= w_own_undef;
          end
        end
        HANDOVER_YEL: begin
          r_undef <= w_own_undef;
          if (r_cnt == '0) begin
            r_fsm   <= HANDOVER_RED;
            r_state <= RED;
            r_cnt   <= RED_LOAD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        HANDOVER_RED: begin
          if (r_cnt == '0) begin
            // Target is whoever wins on this final cycle, possibly the old owner.
            r_owner     <= w_winner;
            r_state     <= w_win_light;
            r_undef     <= w_win_undef;
            r_fsm       <= PASS;
            r_switching <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - CW'(1);
            r_undef <= w_own_undef;
          end
        end
        default: begin
          r_fsm <= PASS;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign owner     = r_owner;
  assign switching = r_switching;
  assign conflict  = r_conflict;
  assign undef_in  = r_undef;

endmodule

// File: tb/tb_light_source_arbiter.sv
// ---------------------------------------------------------------------------
// tb_light_source_arbiter
// Directed scenarios followed by randomized stimulus, all checked against a
// behavioural model that tracks the remaining handover time as a plain count.
// ---------------------------------------------------------------------------
module tb_light_source_arbiter;

  localparam int N  = 6;
  localparam int Y  = 3;
  localparam int R  = 2;
  localparam int OW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  src_state = '0;
  logic [1:0]      state;
  logic [OW-1:0]   owner;
  logic            switching;
  logic            conflict;
  logic            undef_in;

  int total = 0;
  int bad   = 0;

  // Model state: m_left = cycles of handover still to be shown (0 = passing).
  int m_owner, m_state, m_left, m_conf, m_undef;

  always #5 clk = ~clk;

  light_source_arbiter #(
    .N_SRC    (N),
    .YEL_CYC  (Y),
    .RED_CYC  (R),
    .FALLBACK (2'b00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .src_state (src_state),
    .state     (state),
    .owner     (owner),
    .switching (switching),
    .conflict  (conflict),
    .undef_in  (undef_in)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int src_val(input int i);
    return int'(src_state[2*i +: 2]);
  endfunction

  // What the lamps should show for source i (N = none -> fallback RED).
  function automatic int shown(input int i);
    if (i >= N) return 0;
    return (src_val(i) == 3) ? 0 : src_val(i);
  endfunction

  function automatic int bad_src(input int i);
    return (i < N && src_val(i) == 3) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_owner = N; m_state = 0; m_left = 0; m_conf = 0; m_undef = 0;
  endtask

  task automatic model_edge();
    int w;
    int nbits;
    w = N;
    nbits = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        nbits++;
        if (w == N) w = i;
      end
    end
    m_conf = (nbits > 1) ? 1 : 0;
    if (m_left == 0) begin
      if (w == m_owner) begin
        m_state = shown(m_owner); m_undef = bad_src(m_owner);
      end else if (m_state == 0) begin
        m_owner = w; m_state = shown(w); m_undef = bad_src(w);
      end else begin
        m_left = Y + R; m_state = 1; m_undef = bad_src(m_owner);
      end
    end else begin
      m_undef = bad_src(m_owner);
      m_left--;
      if (m_left == 0) begin
        m_owner = w; m_state = shown(w); m_undef = bad_src(w);
      end else begin
        m_state = (m_left > R) ? 1 : 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "/state"},     int'(state),     m_state);
    check_val({tag, "/owner"},     int'(owner),     m_owner);
    check_val({tag, "/switching"}, int'(switching), (m_left != 0) ? 1 : 0);
    check_val({tag, "/conflict"},  int'(conflict),  m_conf);
    check_val({tag, "/undef_in"},  int'(undef_in),  m_undef);
  endtask

  task automatic step(input string tag, input bit verbose);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    if (verbose)
      $display("%-10s req=%b src=%h state=%0d owner=%0d sw=%0b conf=%0b undef=%0b",
               tag, req, src_state, state, owner, switching, conflict, undef_in);
  endtask

  task automatic set_src(input int i, input int v);
    src_state[2*i +: 2] = 2'(v);
  endtask

  int exp_st [6] = '{1, 1, 1, 0, 0, 2};
  int exp_sw [6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    model_reset();

    // Reset values.
    #12;
    check_all("reset");
    check_val("reset/owner_none", int'(owner), 6);
    $display("reset      state=%0d owner=%0d", state, owner);
    @(negedge clk);
    rst_n = 1'b1;

    // Adopt from RED, then pass-through with one-cycle latency.
    req = 6'b000100; set_src(2, 2);
    step("adopt2", 1'b1);
    check_val("adopt2/owner", int'(owner), 2);
    for (int k = 0; k < 4; k++) begin
      set_src(2, (k % 2 == 0) ? 1 : 2);
      step("pass", 1'b1);
      check_val("pass/state", int'(state), (k % 2 == 0) ? 1 : 2);
    end

    // Safe handover owner 2 GREEN -> source 0 GREEN.
    req = 6'b000001; set_src(0, 2);
    for (int k = 0; k < 6; k++) begin
      step("handover", 1'b1);
      check_val("handover/state", int'(state), exp_st[k]);
      check_val("handover/switching", int'(switching), exp_sw[k]);
    end
    check_val("handover/owner", int'(owner), 0);

    // Handover to source 3 showing RED, then immediate adopt of source 5.
    req = 6'b001000; set_src(3, 0);
    for (int k = 0; k < 6; k++) step("to3", 1'b1);
    check_val("to3/owner", int'(owner), 3);
    req = 6'b100000; set_src(5, 2);
    step("imm5", 1'b1);
    check_val("imm5/owner", int'(owner), 5);
    check_val("imm5/state", int'(state), 2);
    check_val("imm5/switching", int'(switching), 0);

    // Conflict and undefined source code.
    set_src(5, 0);
    step("red5", 1'b1);
    req = 6'b000101; set_src(0, 2);
    step("conflict", 1'b1);
    check_val("conflict/owner", int'(owner), 0);
    check_val("conflict/flag", int'(conflict), 1);
    set_src(0, 3);
    step("undef", 1'b1);
    check_val("undef/state", int'(state), 0);
    check_val("undef/flag", int'(undef_in), 1);

    // Request drop during the yellow phase.
    set_src(0, 2);
    step("green0", 1'b1);
    req = 6'b000010; set_src(1, 2);
    step("drop_start", 1'b1);
    req = '0;
    for (int k = 0; k < 5; k++) step("drop", 1'b1);
    check_val("drop/owner", int'(owner), 6);
    check_val("drop/state", int'(state), 0);

    // Asynchronous reset mid-handover.
    req = 6'b000001;
    step("adopt0", 1'b1);
    req = 6'b000100; set_src(2, 2);
    step("ho_rst", 1'b1);
    step("ho_rst", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check_val("async_rst/state", int'(state), 0);
    check_val("async_rst/owner", int'(owner), 6);
    check_val("async_rst/switching", int'(switching), 0);
    $display("async_rst  state=%0d owner=%0d sw=%0b", state, owner, switching);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1);
    check_val("post_rst/owner", int'(owner), 2);
    check_val("post_rst/state", int'(state), 2);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0)
        req = N'($urandom_range(0, 63) & $urandom_range(0, 63));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) set_src(i, $urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        $display("rand_rst   cycle=%0d", c);
        #1;
        rst_n = 1'b1;
      end
      step("rand", 1'b0);
      if (c % 250 == 249)
        $display("rand       cycles=%0d checks=%0d", c + 1, total);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
